// File: rtl/lut_loader_pkg.sv
// Shared types and constants for the lut_loader branch-target table loader.
package lut_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LO,
    HI,
    CHK,
    DONE
  } state_t;

  localparam int DEF_D = 12;
  localparam int DEF_A = 6;

  // A length byte of zero requests a full table load.
  localparam logic [7:0] LEN_FULL = 8'd0;

  function automatic int unsigned load_len(input logic [7:0] len_byte,
                                           input int unsigned depth);
    int unsigned n;
    n = {24'd0, len_byte};
    if (len_byte == LEN_FULL || n > depth) n = depth;
    return n;
  endfunction

endpackage

// File: rtl/lut_store.sv
// 2**A x D register file: one synchronous write port, one combinational read
// port, synchronous active-low clear of every entry.
module lut_store
  import lut_loader_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [A-1:0] raddr,
  output logic [D-1:0] rdata
);

  logic [D-1:0] mem [2**A];

  // NOTE: the table must read 0 after reset, so this storage is deliberately
  // cleared; that keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**A; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_loader.sv
// Byte-stream loader for a writable branch-target table with combinational lookup.
// Optional trailing checksum byte enabled by defining LUT_LOADER_CHECKSUM_EN.
module lut_loader
  import lut_loader_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A-1:0] addr,
  output logic [D-1:0] target,
  output logic         busy,
  output logic         done,
  output logic [A:0]   count,
  output logic         err
);

  localparam int unsigned DEPTH = 1 << A;

  state_t     state_q, state_d;
  logic [A:0] len_q, count_q;
  logic [7:0] lo_q;
  logic       accept, last_pair, wr_en;

  assign in_ready  = state_q inside {LEN, LO, HI, CHK};
  assign busy      = in_ready;
  assign done      = (state_q == DONE);
  assign count     = count_q;
  // Start wins over the handshake: a byte offered alongside it is dropped.
  assign accept    = in_valid && in_ready && !start;
  assign last_pair = (count_q + 1'b1) >= len_q;
  assign wr_en     = accept && (state_q == HI);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path through the case leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LEN;
    end else if (accept) begin
      case (state_q)
        LEN: state_d = LO;
        LO:  state_d = HI;
        HI: begin
          if (!last_pair) state_d = LO;
`ifdef LUT_LOADER_CHECKSUM_EN
          else            state_d = CHK;
`else
          else            state_d = DONE;
`endif
        end
        CHK:     state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q   <= '0;
      count_q <= '0;
      lo_q    <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (accept) begin
      case (state_q)
        LEN:     len_q   <= (A+1)'(load_len(in_byte, DEPTH));
        LO:      lo_q    <= in_byte;
        HI:      count_q <= count_q + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  // Running mod-256 sum of the length byte and every data byte.
  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (state_q == CHK) err_q <= (in_byte != sum_q);
      else                sum_q <= sum_q + in_byte;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  lut_store #(.D(D), .A(A)) u_store (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (wr_en),
    .waddr  (count_q[A-1:0]),
    .wdata  ({in_byte[D-9:0], lo_q}),
    .raddr  (addr),
    .rdata  (target)
  );

endmodule
